dual_input_conditioner: RTL
===========================

# dual_input_conditioner

Front-end stage that drives the two control inputs A and B of the two-input Moore state machine. Each of two raw, asynchronous, possibly bouncing inputs (push-buttons or external strobes) is synchronised into `clk`, debounced by a per-channel stability counter, and presented as a clean level plus a single-cycle rising-edge pulse. The Moore FSM's `A`/`B` ports connect directly to this block's level outputs `A`/`B`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles the synchronised input must hold a new value before the level output changes; legal range 1 to 2^`CNT_W`.
- `CNT_W`, default 8: width of each channel's debounce counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `a_raw`  input  1  raw asynchronous input, channel A.
- `b_raw`  input  1  raw asynchronous input, channel B.
- `A`  output  1  debounced level, channel A (to FSM input A).
- `B`  output  1  debounced level, channel B (to FSM input B).
- `a_pulse`  output  1  one-cycle pulse on each 0->1 transition of `A`.
- `b_pulse`  output  1  one-cycle pulse on each 0->1 transition of `B`.

## Operation
- Channels A and B are identical and fully independent; no priority or mutual exclusion between them.
- Per channel, the registered state is `sync1`, `sync2`, `cnt[CNT_W-1:0]`, level (`A`/`B`) and pulse. All are registered outputs; no combinational path from `*_raw` to any output.
- Synchroniser: `sync1 <= raw`; `sync2 <= sync1`.
- Debounce, evaluated every edge, with `lvl` the current level output:
  - `sync2 == lvl`: `cnt <= 0`, `lvl` unchanged.
  - `sync2 != lvl` and `cnt == DEBOUNCE_CYCLES-1`: `lvl <= sync2`, `cnt <= 0`.
  - `sync2 != lvl` otherwise: `cnt <= cnt + 1`.
- Pulse: `pulse <= 1` only on the edge where `lvl` goes 0->1; otherwise `pulse <= 0`. A 1->0 level transition produces no pulse.
- Counter never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- Glitch rejection: any return of `sync2` to `lvl` before the count completes clears `cnt`. The next deviation restarts the full count.
- Reset: while `rst` is high at an edge, `sync1`, `sync2`, `cnt`, `A`, `B`, `a_pulse` and `b_pulse` all load 0.
  - Reset asserted mid-count or mid-pulse aborts the operation immediately. A pending pulse is dropped.
  - A raw input held at 1 through reset requires the full latency below after release, then produces a normal pulse.

## Timing
- Reset values: `A`=0, `B`=0, `a_pulse`=0, `b_pulse`=0.
- Latency: `raw` stable from just before edge k; `lvl` (and `pulse` on a rise) update at edge k+1+`DEBOUNCE_CYCLES`. With the default of 4, this is edge k+5.
- `pulse` is high for exactly one cycle and coincides with the first cycle of the new high level.
- Minimum accepted input width is `DEBOUNCE_CYCLES` cycles at `sync2`. Shorter excursions never reach the outputs.
- Simultaneous transitions on both channels give coincident, independent updates and pulses.

## Test plan
Defaults `DEBOUNCE_CYCLES`=4, 10 ns clock.
- **Reset:** `rst`=1 for 2 edges with `a_raw`=`b_raw`=1 -> all outputs 0 during reset. After release, `A`=`B`=1 with `a_pulse`=`b_pulse`=1 for one cycle, exactly 5 edges after the first non-reset edge.
- **Clean rise/fall on A:** `a_raw` 0->1 before edge k, held -> `A`=1 and `a_pulse`=1 at edge k+5, `a_pulse`=0 at k+6. `a_raw` 1->0 later -> `A`=0 five edges later, no pulse. `B` and `b_pulse` stay 0 throughout.
- **Bounce rejection:** `a_raw` toggles high 3 cycles, low 1, high 2, low 1, then steady high -> no output change until 5 edges after the steady high begins. Exactly one `a_pulse`.
- **Short glitch:** `b_raw` high for 3 cycles only -> `B` and `b_pulse` remain 0.
- **Simultaneous inputs:** `a_raw` and `b_raw` rise before the same edge -> `A`, `B`, `a_pulse`, `b_pulse` all assert on the same edge k+5.
- **Reset mid-count:** `a_raw` rises, then `rst`=1 for one edge 3 edges later -> outputs 0. After release, `A` rises 5 edges after the release edge, not earlier.

Source files
------------

// File: rtl/dual_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : dual_input_conditioner
//  Purpose  : Conditions two raw, asynchronous, possibly bouncing inputs so
//             they can drive the A/B inputs of a Moore state machine. Each
//             channel is synchronised into clk with two flops, then debounced
//             by a stability counter. The result is a clean level plus a
//             one-cycle pulse on every rising edge of that level.
//  Ports    : clk      - single clock, rising-edge active
//             rst      - synchronous, active-high reset
//             a_raw    - raw asynchronous input, channel A
//             b_raw    - raw asynchronous input, channel B
//             A        - debounced level, channel A
//             B        - debounced level, channel B
//             a_pulse  - one-cycle pulse on each 0->1 transition of A
//             b_pulse  - one-cycle pulse on each 0->1 transition of B
//  Revision : 1.0 - initial release
// ============================================================================
module dual_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,   // legal range 1 .. 2**CNT_W
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic A,
    output logic B,
    output logic a_pulse,
    output logic b_pulse
);

    // Terminal count. The counter stops here and is cleared, so it never wraps.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index 0 is channel A and index 1 is channel B.
    logic [1:0] w_raw;
    logic [1:0] w_lvl;
    logic [1:0] w_pulse;

    assign w_raw = {b_raw, a_raw};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;
        logic             r_pulse;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_cnt   <= '0;
                r_lvl   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
                r_pulse <= 1'b0;
                if (r_sync2 == r_lvl) begin
                    // Any return to the current level discards partial
                    // progress, so the next deviation restarts the full count.
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_lvl   <= r_sync2;
                    r_cnt   <= '0;
                    // A pulse fires only when the new level is high.
                    r_pulse <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        assign w_lvl[i]   = r_lvl;
        assign w_pulse[i] = r_pulse;
    end

    assign A       = w_lvl[0];
    assign B       = w_lvl[1];
    assign a_pulse = w_pulse[0];
    assign b_pulse = w_pulse[1];

endmodule
`default_nettype wire
